// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared CPU constants for the writeback arbiter: requester count and index
// map, register-number and data widths, the arbiter state type, and two small
// index helpers.
// Configuration macro used by the files that import this package:
//   WB_ARB_RR_EN  defined   -> round-robin arbitration
//                 undefined -> fixed priority, requester 0 highest
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int N_REQ     = 5;
    localparam int REQ_IDX_W = 3;
    localparam int RN_W      = 6;
    localparam int DATA_W    = 64;

    // Requester index map (bit position in req_valid / req_ready).
    localparam logic [REQ_IDX_W-1:0] REQ_ALU1    = 3'd0;
    localparam logic [REQ_IDX_W-1:0] REQ_ALU2    = 3'd1;
    localparam logic [REQ_IDX_W-1:0] REQ_ADVINT  = 3'd2;
    localparam logic [REQ_IDX_W-1:0] REQ_MEMUNIT = 3'd3;
    localparam logic [REQ_IDX_W-1:0] REQ_BRANCH  = 3'd4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } arb_state_t;

    // Next requester index in round-robin order, wrapping branch -> alu1.
    function automatic logic [REQ_IDX_W-1:0] next_idx(input logic [REQ_IDX_W-1:0] i);
        return (i == REQ_BRANCH) ? REQ_ALU1 : i + 3'd1;
    endfunction

    // Index of the set bit of a one-hot requester vector (0 if none set).
    function automatic logic [REQ_IDX_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
        logic [REQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = REQ_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_rr_pick
// Round-robin selector. Scans the requesters starting with the one after
// last_grant (wrapping 4 -> 0) and returns a one-hot grant for the first
// requester with its bit set; all-zero grant when no request is set.
// Only instantiated when WB_ARB_RR_EN is defined.
// Ports:
//   req        in  5  request vector
//   last_grant in  3  index of the most recently granted requester
//   grant      out 5  one-hot grant (or zero)
// -----------------------------------------------------------------------------
module wb_rr_pick
    import wb_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0]     req,
    input  logic [REQ_IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0]     grant
);

    logic [REQ_IDX_W-1:0] idx;
    logic                 found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = last_grant;
        // N_REQ steps visit every requester once, last_grant itself last.
        for (int k = 0; k < N_REQ; k++) begin
            idx = next_idx(idx);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter: five execution units compete for one register-file write
// port. A granted request writes its primary result one cycle after
// acceptance; a dual request (req_dual) writes its second result in the cycle
// after that, during which no new grant is given (state SECOND). Every
// non-zero destination written also releases its busy-table entry
// (free_en0 for the primary, free_en1 for the second). Register 0 is the
// constant-zero register, so writes and releases to it are suppressed.
//
// Handshake: a requester raises req_valid[i] with stable payload and holds
// both until it sees req_ready[i]; the request is accepted at the rising
// clk edge where req_valid[i] & req_ready[i]. req_ready is combinational
// from req_valid and the arbitration state, at most one bit high, and never
// depends on the payload of requesters that are not granted.
//
// Configuration: WB_ARB_RR_EN defined -> round-robin arbitration through
// wb_rr_pick with a last-granted pointer (reset to 4); undefined -> fixed
// priority, index 0 highest, no pointer.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   5-bit request / one-hot grant
//   req_data/rn       primary result and destination, packed per requester
//   req_dual          requester also carries data2/rn2
//   req_data2/rn2     second result and destination, packed per requester
//   wb_en/rn/data     register-file write port (registered)
//   free_en0/rn0      busy-table release of the primary destination
//   free_en1/rn1      busy-table release of the second destination
//   dbg_state         current arbiter state
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic [N_REQ*RN_W-1:0]    req_rn,
    input  logic [N_REQ-1:0]         req_dual,
    input  logic [N_REQ*DATA_W-1:0]  req_data2,
    input  logic [N_REQ*RN_W-1:0]    req_rn2,
    output logic                     wb_en,
    output logic [RN_W-1:0]          wb_rn,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     free_en0,
    output logic [RN_W-1:0]          free_rn0,
    output logic                     free_en1,
    output logic [RN_W-1:0]          free_rn1,
    output arb_state_t               dbg_state
);

    arb_state_t           state;
    logic [N_REQ-1:0]     grant;
    logic                 accept;
    logic [REQ_IDX_W-1:0] acc_idx;

    // Pending second result of a dual request.
    logic [RN_W-1:0]      rn2_q;
    logic [DATA_W-1:0]    data2_q;

    // Unpacked per-requester views of the payload buses.
    logic [DATA_W-1:0]    data_a  [N_REQ];
    logic [RN_W-1:0]      rn_a    [N_REQ];
    logic [DATA_W-1:0]    data2_a [N_REQ];
    logic [RN_W-1:0]      rn2_a   [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_a[i]  = req_data[i*DATA_W +: DATA_W];
            rn_a[i]    = req_rn[i*RN_W +: RN_W];
            data2_a[i] = req_data2[i*DATA_W +: DATA_W];
            rn2_a[i]   = req_rn2[i*RN_W +: RN_W];
        end
    end

`ifdef WB_ARB_RR_EN
    logic [REQ_IDX_W-1:0] last_grant;

    wb_rr_pick u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_BRANCH;
        end else if (accept) begin
            last_grant <= acc_idx;
        end
    end
`else
    // Fixed priority: scanning high to low lets the lowest index win.
    always_comb begin
        grant = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

    // No grant while the second result is being written, or while in reset.
    assign req_ready = (rst_n && state == ST_IDLE) ? grant : '0;
    assign accept    = |req_ready;
    assign acc_idx   = onehot_idx(req_ready);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wb_en    <= 1'b0;
            wb_rn    <= '0;
            wb_data  <= '0;
            free_en0 <= 1'b0;
            free_rn0 <= '0;
            free_en1 <= 1'b0;
            free_rn1 <= '0;
            rn2_q    <= '0;
            data2_q  <= '0;
        end else begin
            // Enables are single-cycle pulses; rn/data hold their last value.
            wb_en    <= 1'b0;
            free_en0 <= 1'b0;
            free_en1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wb_en    <= (rn_a[acc_idx] != '0);
                        wb_rn    <= rn_a[acc_idx];
                        wb_data  <= data_a[acc_idx];
                        free_en0 <= (rn_a[acc_idx] != '0);
                        free_rn0 <= rn_a[acc_idx];
                        if (req_dual[acc_idx]) begin
                            rn2_q   <= rn2_a[acc_idx];
                            data2_q <= data2_a[acc_idx];
                            state   <= ST_SECOND;
                        end
                    end
                end
                ST_SECOND: begin
                    wb_en    <= (rn2_q != '0);
                    wb_rn    <= rn2_q;
                    wb_data  <= data2_q;
                    free_en1 <= (rn2_q != '0);
                    free_rn1 <= rn2_q;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter. A reference model keeps a queue of the
// register writes that granted requests still owe the write port; a grant is
// only possible when that queue is empty, and each clock edge pops one write
// onto the outputs. Directed scenarios come first, then randomized traffic.
// Builds for both arbitration modes (WB_ARB_RR_EN defined or not).
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ*RN_W-1:0]   req_rn;
    logic [N_REQ-1:0]        req_dual;
    logic [N_REQ*DATA_W-1:0] req_data2;
    logic [N_REQ*RN_W-1:0]   req_rn2;
    logic                    wb_en;
    logic [RN_W-1:0]         wb_rn;
    logic [DATA_W-1:0]       wb_data;
    logic                    free_en0;
    logic [RN_W-1:0]         free_rn0;
    logic                    free_en1;
    logic [RN_W-1:0]         free_rn1;
    arb_state_t              dbg_state;

    wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_rn    (req_rn),
        .req_dual  (req_dual),
        .req_data2 (req_data2),
        .req_rn2   (req_rn2),
        .wb_en     (wb_en),
        .wb_rn     (wb_rn),
        .wb_data   (wb_data),
        .free_en0  (free_en0),
        .free_rn0  (free_rn0),
        .free_en1  (free_en1),
        .free_rn1  (free_rn1),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Write entry: [71]=valid, [70]=second result, [69:64]=rn, [63:0]=data.
    logic [71:0] exp_q[$];
    logic [71:0] cur;        // write the outputs should currently show
    int          last;       // last granted index (round-robin reference)
    int          last_gi;
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Requester the arbitration rule selects, -1 if none valid.
    function automatic int pick(input logic [N_REQ-1:0] v);
        int j;
`ifdef WB_ARB_RR_EN
        for (int k = 1; k <= N_REQ; k++) begin
            j = (last + k) % N_REQ;
            if (v[j]) return j;
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            j = i;
            if (v[j]) return j;
        end
`endif
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [5:0] rn, input logic [63:0] d,
                           input logic du, input logic [5:0] rn2, input logic [63:0] d2);
        req_valid[i]             = 1'b1;
        req_rn[i*RN_W +: RN_W]   = rn;
        req_data[i*64 +: 64]     = d;
        req_dual[i]              = du;
        req_rn2[i*RN_W +: RN_W]  = rn2;
        req_data2[i*64 +: 64]    = d2;
    endtask

    // One clock cycle: check ready/state/outputs against the model, advance.
    // Called at a negedge with inputs already driven; returns at next negedge.
    task automatic step();
        int               gi;
        logic [N_REQ-1:0] eg;
        logic [5:0]       erd;
        logic             ev, es, ew;
        #1;
        gi = (exp_q.size() == 0) ? pick(req_valid) : -1;
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(eg));
        check("state", 64'(dbg_state), (exp_q.size() != 0) ? 64'(ST_SECOND) : 64'(ST_IDLE));
        ev  = cur[71];
        es  = cur[70];
        erd = cur[69:64];
        ew  = ev && (erd != 6'd0);
        check("wb_en", 64'(wb_en), 64'(ew));
        check("free_en0", 64'(free_en0), 64'(ew && !es));
        check("free_en1", 64'(free_en1), 64'(ew && es));
        if (ew) begin
            check("wb_rn", 64'(wb_rn), 64'(erd));
            check("wb_data", wb_data, cur[63:0]);
            if (es) check("free_rn1", 64'(free_rn1), 64'(erd));
            else    check("free_rn0", 64'(free_rn0), 64'(erd));
        end
        if (gi >= 0) begin
            exp_q.push_back({1'b1, 1'b0, req_rn[gi*RN_W +: RN_W], req_data[gi*64 +: 64]});
            if (req_dual[gi])
                exp_q.push_back({1'b1, 1'b1, req_rn2[gi*RN_W +: RN_W], req_data2[gi*64 +: 64]});
            last = gi;
        end
        last_gi = gi;
        @(posedge clk);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : 72'd0;
        @(negedge clk);
        if (gi >= 0) req_valid[gi] = 1'b0;   // accepted requester drops its request
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},    64'(req_ready), 64'd0);
        check({tag, "_wb_en"},    64'(wb_en),     64'd0);
        check({tag, "_wb_rn"},    64'(wb_rn),     64'd0);
        check({tag, "_wb_data"},  wb_data,        64'd0);
        check({tag, "_free_en0"}, 64'(free_en0),  64'd0);
        check({tag, "_free_rn0"}, 64'(free_rn0),  64'd0);
        check({tag, "_free_en1"}, 64'(free_en1),  64'd0);
        check({tag, "_free_rn1"}, 64'(free_rn1),  64'd0);
        check({tag, "_state"},    64'(dbg_state), 64'(ST_IDLE));
    endtask

    // Asserts reset at the current negedge, checks outputs, releases a cycle later.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        exp_q.delete();
        cur  = 72'd0;
        last = N_REQ - 1;
        #1;
        check_outputs_zero("rst");
        req_valid[0] = 1'b1;             // a request during reset must not be granted
        #1;
        check("rst_ready_gated", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_i;
        logic [5:0] rn, rn2;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_rn    = '0;
        req_dual  = '0;
        req_data2 = '0;
        req_rn2   = '0;
        cur       = 72'd0;
        last      = N_REQ - 1;
        last_gi   = -1;
        @(negedge clk);
        do_reset();

        // All five valid continuously.
        for (int i = 0; i < N_REQ; i++)
            set_req(i, 6'(i + 1), 64'h100 + 64'(i), 1'b0, 6'd0, 64'd0);
        for (int k = 0; k < 6; k++) begin
`ifdef WB_ARB_RR_EN
            exp_i = k % N_REQ;
`else
            exp_i = 0;
`endif
            #1;
            check("grant_seq", 64'(req_ready), 64'(1) << exp_i);
            step();
            req_valid = '1;
        end
        req_valid = '0;
        step();

        // Ten idle cycles.
        for (int k = 0; k < 10; k++) begin
            #1;
            check("idle_ready", 64'(req_ready), 64'd0);
            check("idle_wb_en", 64'(wb_en), 64'd0);
            check("idle_free0", 64'(free_en0), 64'd0);
            check("idle_free1", 64'(free_en1), 64'd0);
            step();
        end

        // alu1 single write.
        set_req(0, 6'd5, 64'h1234, 1'b0, 6'd0, 64'd0);
        #1 check("alu1_ready", 64'(req_ready), 64'h1);
        step();
        check("alu1_wb_en", 64'(wb_en), 64'd1);
        check("alu1_wb_rn", 64'(wb_rn), 64'd5);
        check("alu1_wb_data", wb_data, 64'h1234);
        check("alu1_free_en0", 64'(free_en0), 64'd1);
        check("alu1_free_rn0", 64'(free_rn0), 64'd5);
        step();

        // advint dual; alu1 waits through the SECOND cycle.
        set_req(2, 6'd7, 64'hA, 1'b1, 6'd8, 64'hB);
        #1 check("dual_ready", 64'(req_ready), 64'h4);
        step();
        set_req(0, 6'd9, 64'h99, 1'b0, 6'd0, 64'd0);
        check("dual_p_rn", 64'(wb_rn), 64'd7);
        check("dual_p_free0", 64'(free_en0), 64'd1);
        check("dual_p_free1", 64'(free_en1), 64'd0);
        #1 check("dual_no_ready", 64'(req_ready), 64'd0);
        step();
        check("dual_s_rn", 64'(wb_rn), 64'd8);
        check("dual_s_data", wb_data, 64'hB);
        check("dual_s_free1", 64'(free_en1), 64'd1);
        check("dual_s_free_rn1", 64'(free_rn1), 64'd8);
        check("dual_s_free0", 64'(free_en0), 64'd0);
        check("dual_regrant", 64'(req_ready), 64'h1);
        step();
        step();

        // Dual with rn2 == rn: both writes in order.
        set_req(4, 6'd20, 64'h1, 1'b1, 6'd20, 64'h2);
        step();
        check("same_rn_p_data", wb_data, 64'h1);
        step();
        check("same_rn_s_data", wb_data, 64'h2);
        check("same_rn_s_free1", 64'(free_en1), 64'd1);
        step();

        // memunit writes r0: suppressed.
        set_req(3, 6'd0, 64'hFF, 1'b0, 6'd0, 64'd0);
        #1 check("r0_ready", 64'(req_ready), 64'h8);
        step();
        check("r0_wb_en", 64'(wb_en), 64'd0);
        check("r0_free_en0", 64'(free_en0), 64'd0);
        step();

        // Reset in the cycle after a dual acceptance.
        set_req(1, 6'd12, 64'h55, 1'b1, 6'd13, 64'h66);
        step();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("post_rst_wb_en", 64'(wb_en), 64'd0);
            check("post_rst_free1", 64'(free_en1), 64'd0);
            step();
        end

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i]) begin
                    rn  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                    rn2 = ($urandom_range(0, 4) == 0) ? rn   : 6'($urandom_range(0, 63));
                    set_req(i, rn, {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
                            rn2, {$urandom, $urandom});
                    // Some idle requesters keep garbage payload with valid low.
                    if ($urandom_range(0, 2) != 0) req_valid[i] = 1'b0;
                end
            end
            step();
        end
        req_valid = '0;
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
